// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: handshake, payload and control bundle of one elastic pipeline stage
interface pipe_stage_elastic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  out_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  in_flush;
  logic                  in_clr_cnt;
  logic [CNT_WIDTH-1:0]  out_bp_cnt;
  modport master (
    output in_valid, in_data, in_ctrl, in_ready, in_flush, in_clr_cnt,
    input  out_ready, out_valid, out_data, out_ctrl, out_bp_cnt
  );
  modport slave (
    input  in_valid, in_data, in_ctrl, in_ready, in_flush, in_clr_cnt,
    output out_ready, out_valid, out_data, out_ctrl, out_bp_cnt
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline stage with optional skid entry, flush and back-pressure counter
module pipe_stage_elastic #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = 8,
  parameter int SKID                = 0,
  parameter int CTRL_ZERO_ON_BUBBLE = 1,
  parameter int CNT_WIDTH           = 16
) (
  input logic                clk,
  input logic                rst_n,
  pipe_stage_elastic_if.slave bus
);
  logic                  main_v, skid_v;
  logic [DATA_WIDTH-1:0] main_d, skid_d;
  logic [CTRL_WIDTH-1:0] main_c, skid_c;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  rdy, accept, pop, to_skid;
  assign rdy     = (SKID != 0) ? ~skid_v : (~main_v | bus.in_ready);
  assign accept  = bus.in_valid & rdy;
  assign pop     = main_v & bus.in_ready;
  // only reachable with the skid entry: the ready of the single-entry form excludes it
  assign to_skid = accept & main_v & ~bus.in_ready;
  assign bus.out_ready  = rdy;
  assign bus.out_valid  = main_v;
  assign bus.out_data   = main_d;
  assign bus.out_ctrl   = (CTRL_ZERO_ON_BUBBLE != 0 && !main_v) ? '0 : main_c;
  assign bus.out_bp_cnt = cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      main_c <= '0;
      skid_c <= '0;
    end else if (bus.in_flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (pop) begin
        main_d <= skid_d;
        main_c <= skid_c;
        skid_v <= 1'b0;
      end
    end else if (to_skid) begin
      skid_d <= bus.in_data;
      skid_c <= bus.in_ctrl;
      skid_v <= 1'b1;
    end else if (accept) begin
      main_d <= bus.in_data;
      main_c <= bus.in_ctrl;
      main_v <= 1'b1;
    end else if (pop) begin
      main_v <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (bus.in_clr_cnt) cnt <= '0;
    else if (main_v && !bus.in_ready && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: three stage variants (no skid, skid, 2-bit counter) against an occupancy FIFO model
module tb_pipe_stage_elastic;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  pipe_stage_elastic_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CNT_WIDTH(16)) if0 ();
  pipe_stage_elastic_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CNT_WIDTH(16)) if1 ();
  pipe_stage_elastic_if #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .CNT_WIDTH(2))  if2 ();
  pipe_stage_elastic #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .SKID(0), .CNT_WIDTH(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pipe_stage_elastic #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .SKID(1), .CNT_WIDTH(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipe_stage_elastic #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .SKID(0), .CNT_WIDTH(2))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  logic [2:0]  vld;
  logic [31:0] dat;
  logic [7:0]  ctl;
  logic        rdy, flush, clr;
  assign if0.in_valid = vld[0]; assign if1.in_valid = vld[1]; assign if2.in_valid = vld[2];
  assign if0.in_data = dat; assign if1.in_data = dat; assign if2.in_data = dat;
  assign if0.in_ctrl = ctl; assign if1.in_ctrl = ctl; assign if2.in_ctrl = ctl;
  assign if0.in_ready = rdy; assign if1.in_ready = rdy; assign if2.in_ready = rdy;
  assign if0.in_flush = flush; assign if1.in_flush = flush; assign if2.in_flush = flush;
  assign if0.in_clr_cnt = clr; assign if1.in_clr_cnt = clr; assign if2.in_clr_cnt = clr;
  logic [2:0]  o_rdy, o_vld;
  logic [31:0] o_dat [3];
  logic [7:0]  o_ctl [3];
  logic [15:0] o_bp  [3];
  assign o_rdy = {if2.out_ready, if1.out_ready, if0.out_ready};
  assign o_vld = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign o_dat[0] = if0.out_data; assign o_dat[1] = if1.out_data; assign o_dat[2] = if2.out_data;
  assign o_ctl[0] = if0.out_ctrl; assign o_ctl[1] = if1.out_ctrl; assign o_ctl[2] = if2.out_ctrl;
  assign o_bp[0] = if0.out_bp_cnt; assign o_bp[1] = if1.out_bp_cnt; assign o_bp[2] = {14'd0, if2.out_bp_cnt};
  int checks = 0;
  int fails = 0;
  int          occ [3];
  logic [31:0] ed [3][2];
  logic [7:0]  ec [3][2];
  int          mc [3];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      occ[k] = 0;
      mc[k] = 0;
    end
  endtask
  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_valid", k), 64'(o_vld[k]), 0);
      chk($sformatf("u%0d_rst_data", k), 64'(o_dat[k]), 0);
      chk($sformatf("u%0d_rst_ctrl", k), 64'(o_ctl[k]), 0);
      chk($sformatf("u%0d_rst_bp", k), 64'(o_bp[k]), 0);
      chk($sformatf("u%0d_rst_ready", k), 64'(o_rdy[k]), 1);
    end
  endtask
  // one cycle: drive, compare against model occupancy, advance model, cross the clock edge
  task automatic step(input logic [2:0] v, input logic [31:0] d, input logic [7:0] c, input logic r, input logic f, input logic cl);
    vld = v; dat = d; ctl = c; rdy = r; flush = f; clr = cl;
    #1;
    for (int k = 0; k < 3; k++) begin
      automatic logic er = (k == 1) ? (occ[k] < 2) : (occ[k] == 0 || r);
      automatic logic acc = v[k] & er;
      automatic logic pp = (occ[k] > 0) & r;
      automatic int cap = (k == 2) ? 3 : 65535;
      chk($sformatf("u%0d_ready", k), 64'(o_rdy[k]), 64'(er));
      chk($sformatf("u%0d_valid", k), 64'(o_vld[k]), 64'(occ[k] > 0));
      if (occ[k] > 0) begin
        chk($sformatf("u%0d_data", k), 64'(o_dat[k]), 64'(ed[k][0]));
        chk($sformatf("u%0d_ctrl", k), 64'(o_ctl[k]), 64'(ec[k][0]));
      end else chk($sformatf("u%0d_ctrl_bubble", k), 64'(o_ctl[k]), 0);
      chk($sformatf("u%0d_bp", k), 64'(o_bp[k]), 64'(mc[k]));
      if (cl) mc[k] = 0;
      else if (occ[k] > 0 && !r && mc[k] < cap) mc[k]++;
      if (f) occ[k] = 0;
      else begin
        if (pp) begin
          ed[k][0] = ed[k][1];
          ec[k][0] = ec[k][1];
          occ[k]--;
        end
        if (acc) begin
          ed[k][occ[k]] = d;
          ec[k][occ[k]] = c;
          occ[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  int bp_exp [5] = '{1, 2, 0, 1, 2};
  initial begin
    rst_n = 1'b0;
    vld = 0; dat = 0; ctl = 0; rdy = 0; flush = 0; clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // back-to-back stream at full throughput
    for (int i = 1; i <= 3; i++) begin
      step(3'b111, 32'(i), 8'h11, 1'b1, 1'b0, 1'b0);
      chk("stream_data", 64'(o_dat[0]), 64'(i));
      chk("stream_valid", 64'(o_vld[0]), 1);
    end
    chk("stream_bp", 64'(o_bp[0]), 0);
    step(3'b000, 0, 0, 1'b1, 1'b0, 1'b0);
    // stall counting with a mid-run clear, then saturation of the 2-bit counter
    step(3'b111, 32'h30, 8'h22, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(3'b000, 0, 0, 1'b0, 1'b0, i == 2);
      chk("bp_seq", 64'(o_bp[0]), 64'(bp_exp[i]));
    end
    repeat (6) step(3'b000, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("bp_sat", 64'(o_bp[2]), 3);
    chk("bp_long", 64'(o_bp[0]), 8);
    step(3'b000, 0, 0, 1'b1, 1'b0, 1'b0);
    // skid capture and in-order drain
    step(3'b111, 32'hA, 8'h3C, 1'b0, 1'b0, 1'b0);
    rdy = 1'b1; #1;
    chk("skid_ready_no_comb_hi", 64'(o_rdy[1]), 1);
    chk("noskid_ready_comb_hi", 64'(o_rdy[0]), 1);
    rdy = 1'b0; #1;
    chk("skid_ready_no_comb_lo", 64'(o_rdy[1]), 1);
    chk("noskid_ready_comb_lo", 64'(o_rdy[0]), 0);
    step(3'b111, 32'hB, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("skid_full_ready", 64'(o_rdy[1]), 0);
    rdy = 1'b1; #1;
    chk("skid_full_ready_comb", 64'(o_rdy[1]), 0);
    step(3'b111, 32'hC, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("skid_hold_data", 64'(o_dat[1]), 32'hA);
    step(3'b111, 32'hC, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("skid_order_b", 64'(o_dat[1]), 32'hB);
    step(3'b111, 32'hC, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("skid_order_c", 64'(o_dat[1]), 32'hC);
    step(3'b000, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("skid_drained", 64'(o_vld[1]), 0);
    // flush with both entries full and a beat on offer
    step(3'b111, 32'h11, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(3'b111, 32'h22, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(3'b111, 32'hF, 8'hFF, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 64'(o_vld[1]), 0);
    chk("flush_ctrl", 64'(o_ctl[1]), 0);
    repeat (3) begin
      step(3'b000, 0, 0, 1'b1, 1'b0, 1'b0);
      chk("flush_no_emit", 64'(o_vld[1]), 0);
    end
    // asynchronous reset between edges with a beat pending
    step(3'b111, 32'h77, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(o_vld[0]), 1);
    vld = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    model_reset();
    #1 rst_n = 1'b1;
    step(3'b111, 32'h5, 8'h66, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(o_vld[0]), 1);
    chk("post_rst_data", 64'(o_dat[0]), 32'h5);
    for (int i = 0; i < 10000; i++)
      step(3'($urandom), $urandom, 8'($urandom), ($urandom % 4) != 0, ($urandom % 32) == 0, ($urandom % 64) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
